// File: rtl/pc_unit.sv
// Fetch program counter: advances by 4 on fetch acceptance, redirects on taken
// jumps/branches, and forces the trap address on faults or misaligned targets.
module pc_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_unit_valid,
    input  logic        valid,
    input  logic [1:0]  jmp_op,
    input  logic        cmp,
    input  logic [31:0] next_addr,
    input  logic        fault,
    output logic [31:0] addr
);

    localparam logic [1:0] OP_JUMP   = 2'd1;
    localparam logic [1:0] OP_BRANCH = 2'd2;

    logic        redirect_taken;
    logic        branch_not_taken;
    logic        target_misaligned;
    logic [31:0] addr_next;

    always_comb begin
        redirect_taken    = valid && ((jmp_op == OP_JUMP) || ((jmp_op == OP_BRANCH) && cmp));
        branch_not_taken  = valid && (jmp_op == OP_BRANCH) && !cmp;
        target_misaligned = (next_addr[1:0] != 2'b00);

        // Priority order: fault, taken redirect, not-taken branch hold, increment, stall.
        addr_next = addr;
        if (fault) begin
            addr_next = TRAP_ADDR;
        end else if (redirect_taken) begin
            addr_next = target_misaligned ? TRAP_ADDR : next_addr;
        end else if (branch_not_taken) begin
            // Fall-through fetch is already in flight, so the PC must not advance.
            addr_next = addr;
        end else if (fetch_unit_valid) begin
            addr_next = addr + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= RESET_ADDR;
        end else begin
            addr <= addr_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver predicts each next PC from the
// selection rules and queues it; a monitor compares addr one half-cycle later.
module tb_pc_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] TRAP_ADDR  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_unit_valid;
  logic        valid;
  logic [1:0]  jmp_op;
  logic        cmp;
  logic [31:0] next_addr;
  logic        fault;
  logic [31:0] addr;

  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  int          checks;
  int          errors;
  int          seq_no;

  pc_unit #(
    .RESET_ADDR(RESET_ADDR),
    .TRAP_ADDR (TRAP_ADDR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_unit_valid(fetch_unit_valid),
    .valid           (valid),
    .jmp_op          (jmp_op),
    .cmp             (cmp),
    .next_addr       (next_addr),
    .fault           (fault),
    .addr            (addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: next PC from the prioritized selection rules
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic fv, input logic v,
                                           input logic [1:0] op, input logic c,
                                           input logic [31:0] na, input logic f);
    logic [32:0] sum;
    if (f) return TRAP_ADDR;
    if (v && (op == 2'd1 || (op == 2'd2 && c))) begin
      if (na % 4 != 0) return TRAP_ADDR;
      return na;
    end
    if (v && op == 2'd2) return cur;
    if (fv) begin
      sum = {1'b0, cur} + 33'd4;
      return sum[31:0];
    end
    return cur;
  endfunction

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: addr=%h expected=%h", name, got, want);
    end
  endtask

  // driver: apply one cycle of inputs, predict the result, queue it
  task automatic drive(input logic fv, input logic v, input logic [1:0] op, input logic c,
                       input logic [31:0] na, input logic f);
    fetch_unit_valid = fv;
    valid            = v;
    jmp_op           = op;
    cmp              = c;
    next_addr        = na;
    fault            = f;
    @(posedge clk);
    model_pc = ref_next(model_pc, fv, v, op, c, na, f);
    exp_q.push_back(model_pc);
    #2;
  endtask

  task automatic idle_inputs();
    fetch_unit_valid = 1'b0;
    valid            = 1'b0;
    jmp_op           = 2'd0;
    cmp              = 1'b0;
    next_addr        = 32'h0;
    fault            = 1'b0;
  endtask

  // monitor: compare addr against the queued prediction away from the active edge
  initial begin
    logic [31:0] exp;
    seq_no = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        seq_no++;
        if (addr !== exp) begin
          errors++;
          $display("FAIL addr_seq #%0d: addr=%h expected=%h", seq_no, addr, exp);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] na;
    logic        f;
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n    = 1'b0;
    model_pc = RESET_ADDR;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_hold", addr, RESET_ADDR);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_now("reset_release", addr, RESET_ADDR);

    // sequential fetch and NOP op
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 0
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 4
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);   // 8
    // jump, not-taken branch, taken branch
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'd20, 1'b0);  // 20
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'd40, 1'b0);  // holds 20
    drive(1'b0, 1'b1, 2'd2, 1'b1, 32'd40, 1'b0);  // 40
    // stall
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 44
    repeat (3) drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    // misaligned targets
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'd1, 1'b0);   // 44
    drive(1'b0, 1'b1, 2'd2, 1'b1, 32'd1, 1'b0);   // trap
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 4
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h6, 1'b0);   // trap
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 4
    // fault beats a taken jump and fetch
    drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h100, 1'b1); // trap
    // wrap and reserved op
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 0
    drive(1'b1, 1'b1, 2'd3, 1'b1, 32'h200, 1'b0); // 4
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h80, 1'b0);  // 0x80

    // asynchronous reset between edges, in the middle of a pending redirect
    @(negedge clk);
    fetch_unit_valid = 1'b1;
    valid            = 1'b1;
    jmp_op           = 2'd1;
    next_addr        = 32'h400;
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", addr, RESET_ADDR);
    model_pc = RESET_ADDR;
    @(posedge clk);
    #1;
    check_now("reset_discards_redirect", addr, RESET_ADDR);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);   // 4

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       na = {$urandom(), 2'b00} >> 2 << 2;
        1:       na = $urandom();
        2:       na = 32'hFFFF_FFFC - 32'($urandom_range(0, 3)) * 4;
        default: na = 32'($urandom_range(0, 63));
      endcase
      f = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), na, f);
    end
    idle_inputs();

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
